// File: rtl/zbus_pkg.sv
// zbus_pkg: shared zbus definitions.
//   - Default bus/memory geometry used by zbus slaves, masters and bridges.
//   - zbus_rsp_t: bus-level response entry {adr, dat} at default widths.
//   - fifo_aw(): pointer width helper for power-of-two FIFOs.
package zbus_pkg;

  localparam int ZB_WA = 32;  // address width
  localparam int ZB_WD = 32;  // data width
  localparam int ZB_WM = 4;   // memory index width (depth 2**ZB_WM)
  localparam int ZB_FD = 4;   // response FIFO depth

  typedef struct packed {
    logic [ZB_WA-1:0] adr;
    logic [ZB_WD-1:0] dat;
  } zbus_rsp_t;

  // Pointer width for a FIFO of depth fd; never narrower than one bit.
  function automatic int fifo_aw(input int fd);
    return (fd <= 2) ? 1 : $clog2(fd);
  endfunction

endpackage

// File: rtl/zbus_fifo.sv
// zbus_fifo: synchronous FIFO with a registered head.
//   clk   : clock
//   rst   : asynchronous active-low reset (pointers, count and head cleared)
//   push  : write din (ignored when full)
//   din   : entry to write
//   pop   : consume the head (ignored when empty)
//   dout  : registered head entry; holds its last value while empty
//   full  : count == FD
//   empty : count == 0
//   count : number of stored entries
module zbus_fifo
  import zbus_pkg::*;
#(
  parameter int W  = 8,
  parameter int FD = 4,
  localparam int AW = fifo_aw(FD),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_reg [FD];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW-1:0] rd_ptr_inc;
  logic [CW-1:0] count_reg, count_next;
  logic [W-1:0]  dout_reg, dout_next;
  logic          push_ok, pop_ok;

  assign full    = (count_reg == CW'(FD));
  assign empty   = (count_reg == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_ptr_inc = rd_ptr_reg + AW'(1);

  // Storage carries no reset; only the bookkeeping does.
  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= din;
  end

  // The head register must always show the oldest live entry. It takes
  // din directly when the pushed entry becomes the head (FIFO empty, or
  // its only entry leaving this cycle); otherwise after a pop it takes
  // the next stored entry.
  always_comb begin
    dout_next  = dout_reg;
    count_next = count_reg + CW'(push_ok) - CW'(pop_ok);
    if (push_ok && (empty || (pop_ok && count_reg == CW'(1)))) begin
      dout_next = din;
    end else if (pop_ok && count_reg > CW'(1)) begin
      dout_next = mem_reg[rd_ptr_inc];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      dout_reg   <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_inc;
      count_reg <= count_next;
      dout_reg  <= dout_next;
    end
  end

  assign dout  = dout_reg;
  assign count = count_reg;

endmodule

// File: rtl/zbus_mem_s.sv
// zbus_mem_s: memory-backed zbus slave.
//   clk   : clock
//   rst   : asynchronous active-low reset
//   w_vld/w_rdy           : request handshake
//   w_aen                 : load pointer from w_adr[WM-1:0]
//   w_den                 : 1 = write, 0 = read
//   w_adr/w_dat           : request address / write data
//   r_vld/r_rdy           : response handshake
//   r_aen/r_den           : both follow r_vld
//   r_adr/r_dat           : zero-extended word index / read data
// Reads push {index, data} into a response FIFO so response back-pressure
// only stalls requests once the FIFO is full.
module zbus_mem_s
  import zbus_pkg::*;
#(
  parameter int WA = ZB_WA,
  parameter int WD = ZB_WD,
  parameter int WM = ZB_WM,
  parameter int FD = ZB_FD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          w_vld,
  input  logic          w_aen,
  input  logic          w_den,
  input  logic [WA-1:0] w_adr,
  input  logic [WD-1:0] w_dat,
  output logic          w_rdy,
  output logic          r_vld,
  output logic          r_aen,
  output logic          r_den,
  output logic [WA-1:0] r_adr,
  output logic [WD-1:0] r_dat,
  input  logic          r_rdy
);

  localparam int DEPTH = 2 ** WM;
  localparam int CW    = fifo_aw(FD) + 1;

  // Only the index is queued; the response address is rebuilt by
  // zero-extension at the output.
  typedef struct packed {
    logic [WM-1:0] idx;
    logic [WD-1:0] dat;
  } rsp_entry_t;

  logic [WD-1:0] mem_reg [DEPTH];
  logic [WM-1:0] ptr_reg;
  logic [WM-1:0] ea;
  logic          w_rdy_reg, w_rdy_next;
  logic          w_fire, wr_en, push, pop;
  rsp_entry_t    push_entry, head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, count_next;
  logic          unused_bits;

  assign w_fire = w_vld & w_rdy_reg;
  assign ea     = w_aen ? w_adr[WM-1:0] : ptr_reg;
  assign wr_en  = w_fire & w_den;
  assign push   = w_fire & ~w_den;
  assign pop    = r_vld & r_rdy;

  // Read data is taken before this edge's write lands; one transfer per
  // cycle means the two never target the same edge anyway.
  assign push_entry.idx = ea;
  assign push_entry.dat = mem_reg[ea];

  always_ff @(posedge clk) begin
    if (wr_en) mem_reg[ea] <= w_dat;
  end

  // Ready looks at the count after this edge, so it drops the cycle after
  // the filling push. A pop at full does not open a same-cycle slot.
  always_comb begin
    count_next = fifo_count + CW'(push) - CW'(pop);
    w_rdy_next = (count_next < CW'(FD));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg   <= '0;
      w_rdy_reg <= 1'b0;
    end else begin
      if (w_fire) ptr_reg <= ea + WM'(1);  // wraps modulo 2**WM
      w_rdy_reg <= w_rdy_next;
    end
  end

  zbus_fifo #(
    .W  ($bits(rsp_entry_t)),
    .FD (FD)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign w_rdy = w_rdy_reg;
  assign r_vld = ~fifo_empty;
  assign r_aen = r_vld;
  assign r_den = r_vld;
  assign r_adr = {{(WA-WM){1'b0}}, head.idx};
  assign r_dat = head.dat;

  // Address bits above the index and the full flag are deliberately unused.
  assign unused_bits = ^{w_adr[WA-1:WM], fifo_full};

endmodule
